// File: rtl/hc595_ctrl_if.sv
// hc595_ctrl_if: system-side load/clear handshake for the 74HC595 chain controller.
// The master is the system logic; the slave is the controller.
interface hc595_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] IN_DATA;
    logic              IN_VALID;
    logic              IN_READY;
    logic              CLR_REQ;
    logic              OUT_EN;
    logic              DONE;

    modport master (
        output IN_DATA, IN_VALID, CLR_REQ, OUT_EN,
        input  IN_READY, DONE
    );

    modport slave (
        input  IN_DATA, IN_VALID, CLR_REQ, OUT_EN,
        output IN_READY, DONE
    );
endinterface

// File: rtl/hc595_ctrl.sv
// hc595_ctrl: serialises a parallel word MSB-first into a chain of 74HC595-style
// devices, then pulses RCK to latch it. A clear command pulses SCLR across a
// single SCK fall and latches the cleared chain.
// Optional build macro: HC595_BLANK_EN -- when defined, OE is held low from the
// accept edge until the controller returns to IDLE.
// All pin outputs are registered from the next state, so they always match the
// current state register.
module hc595_ctrl #(
    parameter int DATA_W = 8,
    parameter int HALF   = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    hc595_ctrl_if.slave bus,
    output logic        SI,
    output logic        SCK,
    output logic        RCK,
    output logic        SCLR,
    output logic        OE
);
    localparam int HCNT_W = $clog2(HALF + 1);
    localparam int BCNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SH_HI  = 3'd1;
    localparam logic [2:0] S_SH_LO  = 3'd2;
    localparam logic [2:0] S_LAT_LO = 3'd3;
    localparam logic [2:0] S_LAT_HI = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic              clr_q, clr_d;
    logic              sck_q, sck_d;
    logic              rck_q, rck_d;
    logic              sclr_q, sclr_d;
    logic              si_q, si_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              oe_q, oe_d;
    logic              shifting_d;

    // Next-state, counters and shadow register; every state change reloads the half-period counter.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        bcnt_d   = bcnt_q;
        shadow_d = shadow_q;
        clr_d    = clr_q;
        case (state_q)
            S_IDLE: begin
                // ready_q is low for the first cycle after reset, so nothing is taken then.
                if (ready_q) begin
                    if (bus.CLR_REQ) begin
                        clr_d   = 1'b1;
                        bcnt_d  = BCNT_W'(1);
                        state_d = S_SH_HI;
                    end else if (bus.IN_VALID) begin
                        shadow_d = bus.IN_DATA;
                        bcnt_d   = BCNT_W'(DATA_W);
                        state_d  = S_SH_HI;
                    end
                end
            end
            S_SH_HI: begin
                if (hcnt_q == '0) state_d = S_SH_LO;
            end
            S_SH_LO: begin
                if (hcnt_q == '0) begin
                    shadow_d = shadow_q << 1;
                    bcnt_d   = bcnt_q - BCNT_W'(1);
                    state_d  = (bcnt_q == BCNT_W'(1)) ? S_LAT_LO : S_SH_HI;
                end
            end
            S_LAT_LO: begin
                if (hcnt_q == '0) state_d = S_LAT_HI;
            end
            S_LAT_HI: begin
                if (hcnt_q == '0) state_d = S_FIN;
            end
            S_FIN: begin
                clr_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            hcnt_d = HCNT_W'(HALF - 1);
        end else if (hcnt_q != '0) begin
            hcnt_d = hcnt_q - HCNT_W'(1);
        end
    end

    // Pin levels decoded from the next state so the registered pins line up with the state register.
    always_comb begin
        shifting_d = (state_d == S_SH_HI) || (state_d == S_SH_LO);
        sck_d      = (state_d != S_SH_LO);
        rck_d      = (state_d != S_LAT_LO);
        sclr_d     = !(clr_d && shifting_d);
        si_d       = shifting_d && !clr_d && shadow_d[DATA_W-1];
        done_d     = (state_d == S_FIN);
        ready_d    = (state_d == S_IDLE);
`ifdef HC595_BLANK_EN
        oe_d       = (state_d == S_IDLE) ? bus.OUT_EN : 1'b0;
`else
        oe_d       = bus.OUT_EN;
`endif
    end

    // State, counters and registered outputs; reset abandons any transfer without issuing RCK.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            hcnt_q   <= '0;
            bcnt_q   <= '0;
            shadow_q <= '0;
            clr_q    <= 1'b0;
            sck_q    <= 1'b1;
            rck_q    <= 1'b1;
            sclr_q   <= 1'b1;
            si_q     <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            bcnt_q   <= bcnt_d;
            shadow_q <= shadow_d;
            clr_q    <= clr_d;
            sck_q    <= sck_d;
            rck_q    <= rck_d;
            sclr_q   <= sclr_d;
            si_q     <= si_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            oe_q     <= oe_d;
        end
    end

    assign SI           = si_q;
    assign SCK          = sck_q;
    assign RCK          = rck_q;
    assign SCLR         = sclr_q;
    assign OE           = oe_q;
    assign bus.IN_READY = ready_q;
    assign bus.DONE     = done_q;
endmodule

// File: tb/tb_hc595_ctrl.sv
// tb_hc595_ctrl: bench for hc595_ctrl with two instances (8-bit/HALF=2 and a
// 16-bit two-device chain with HALF=1). A behavioural 74HC595 chain model sits
// on the pins of each instance; expected values come from the transfer rules.
module tb_hc595_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    hc595_ctrl_if #(.DATA_W(8))  bus_a();
    hc595_ctrl_if #(.DATA_W(16)) bus_b();

    logic a_si, a_sck, a_rck, a_sclr, a_oe;
    logic b_si, b_sck, b_rck, b_sclr, b_oe;

    hc595_ctrl #(.DATA_W(8), .HALF(2)) u_a (
        .CLK(clk), .RST_N(rst_n), .bus(bus_a.slave),
        .SI(a_si), .SCK(a_sck), .RCK(a_rck), .SCLR(a_sclr), .OE(a_oe)
    );

    hc595_ctrl #(.DATA_W(16), .HALF(1)) u_b (
        .CLK(clk), .RST_N(rst_n), .bus(bus_b.slave),
        .SI(b_si), .SCK(b_sck), .RCK(b_rck), .SCLR(b_sclr), .OE(b_oe)
    );

    // Pin-level chain model and event bookkeeping
    int cyc = 0;
    int a_nfall = 0, a_nrck = 0, a_ndone = 0, a_nacc = 0, a_nclrf = 0;
    int a_cmd_cyc = 0, a_acc_cyc = 0, a_done_cyc = 0, a_prev_done = 0;
    int b_nfall = 0, b_nrck = 0, b_ndone = 0, b_nacc = 0, b_nclrf = 0;
    int b_cmd_cyc = 0, b_acc_cyc = 0, b_done_cyc = 0, b_prev_done = 0;
    logic a_sck_p = 1'b1, a_rck_p = 1'b1, b_sck_p = 1'b1, b_rck_p = 1'b1;
    logic [15:0] a_sr = '0, a_q = '0, b_sr = '0, b_q = '0;
    bit a_siq[$];
    bit b_siq[$];

    always @(posedge clk) begin
        cyc++;
        if (bus_a.IN_READY && (bus_a.CLR_REQ || bus_a.IN_VALID)) a_cmd_cyc = cyc;
        if (bus_a.IN_READY && !bus_a.CLR_REQ && bus_a.IN_VALID) begin
            a_nacc++;
            a_acc_cyc = cyc;
        end
        if (a_sck_p && !a_sck) begin
            a_nfall++;
            a_siq.push_back(a_si);
            if (!a_sclr) begin a_sr = '0; a_nclrf++; end
            else a_sr = {a_sr[14:0], a_si};
        end
        if (a_rck_p && !a_rck) begin a_nrck++; a_q = a_sr; end
        if (bus_a.DONE) begin a_ndone++; a_prev_done = a_done_cyc; a_done_cyc = cyc; end
        a_sck_p = a_sck;
        a_rck_p = a_rck;

        if (bus_b.IN_READY && (bus_b.CLR_REQ || bus_b.IN_VALID)) b_cmd_cyc = cyc;
        if (bus_b.IN_READY && !bus_b.CLR_REQ && bus_b.IN_VALID) begin
            b_nacc++;
            b_acc_cyc = cyc;
        end
        if (b_sck_p && !b_sck) begin
            b_nfall++;
            b_siq.push_back(b_si);
            if (!b_sclr) begin b_sr = '0; b_nclrf++; end
            else b_sr = {b_sr[14:0], b_si};
        end
        if (b_rck_p && !b_rck) begin b_nrck++; b_q = b_sr; end
        if (bus_b.DONE) begin b_ndone++; b_prev_done = b_done_cyc; b_done_cyc = cyc; end
        b_sck_p = b_sck;
        b_rck_p = b_rck;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int sel, input int limit, input string tag);
        int n0;
        bit got;
        n0 = sel ? b_ndone : a_ndone;
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            got = ((sel ? b_ndone : a_ndone) != n0);
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
    endtask

    task automatic wait_acc(input int sel, input int n_target, input int limit, input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            got = ((sel ? b_nacc : a_nacc) >= n_target);
        end
        chk({tag, "_accept_seen"}, 32'(got), 32'd1);
    endtask

    // One transfer, checked against the chain rules: latency, bit order, one latch, final Q.
    task automatic run_xfer(input int sel, input logic [15:0] d, input string tag);
        int dw, h, r0, n0;
        logic [15:0] w, exp_d;
        dw = sel ? 16 : 8;
        h  = sel ? 1 : 2;
        exp_d = sel ? d : {8'h00, d[7:0]};
        @(negedge clk);
        r0 = sel ? b_nrck : a_nrck;
        n0 = sel ? b_nacc : a_nacc;
        if (sel != 0) begin
            b_siq.delete();
            bus_b.IN_DATA = d;
            bus_b.IN_VALID = 1'b1;
        end else begin
            a_siq.delete();
            bus_a.IN_DATA = d[7:0];
            bus_a.IN_VALID = 1'b1;
        end
        wait_acc(sel, n0 + 1, 20, tag);
        bus_a.IN_VALID = 1'b0;
        bus_b.IN_VALID = 1'b0;
        wait_done(sel, 200, tag);
        chk({tag, "_latency"}, 32'(sel ? (b_done_cyc - b_acc_cyc) : (a_done_cyc - a_acc_cyc)),
            32'(2 * h * (dw + 1) + 1));
        chk({tag, "_nbits"}, 32'(sel ? b_siq.size() : a_siq.size()), 32'(dw));
        w = '0;
        if (sel != 0) begin
            foreach (b_siq[i]) w = {w[14:0], b_siq[i]};
        end else begin
            foreach (a_siq[i]) w = {w[14:0], a_siq[i]};
        end
        chk({tag, "_si_order"}, 32'(w), 32'(exp_d));
        chk({tag, "_rck_falls"}, 32'(sel ? (b_nrck - r0) : (a_nrck - r0)), 32'd1);
        chk({tag, "_chain_q"}, 32'(sel ? b_q : {8'h00, a_q[7:0]}), 32'(exp_d));
        chk({tag, "_ready_after"}, 32'(sel ? bus_b.IN_READY : bus_a.IN_READY), 32'd1);
        chk({tag, "_done_one_cycle"}, 32'(sel ? bus_b.DONE : bus_a.DONE), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, r0, c0, n0, d0;
        logic [15:0] rd;
        logic oe_req;

        bus_a.IN_DATA = '0; bus_a.IN_VALID = 1'b0; bus_a.CLR_REQ = 1'b0; bus_a.OUT_EN = 1'b0;
        bus_b.IN_DATA = '0; bus_b.IN_VALID = 1'b0; bus_b.CLR_REQ = 1'b0; bus_b.OUT_EN = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_sck",   32'(a_sck),  32'd1);
        chk("rst_rck",   32'(a_rck),  32'd1);
        chk("rst_sclr",  32'(a_sclr), 32'd1);
        chk("rst_si",    32'(a_si),   32'd0);
        chk("rst_done",  32'(bus_a.DONE), 32'd0);
        chk("rst_oe",    32'(a_oe),   32'd0);
        chk("rst_ready", 32'(bus_a.IN_READY), 32'd0);
        chk("rst_b_ready", 32'(bus_b.IN_READY), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(bus_a.IN_READY), 32'd1);

        // Single transfer
        run_xfer(0, 16'h00A5, "xfer_a5");

        // Clear and data requested together: clear wins, data follows once idle
        @(negedge clk);
        f0 = a_nfall; r0 = a_nrck; c0 = a_nclrf; n0 = a_nacc;
        bus_a.CLR_REQ = 1'b1;
        bus_a.IN_VALID = 1'b1;
        bus_a.IN_DATA = 8'h3C;
        @(negedge clk);
        bus_a.CLR_REQ = 1'b0;
        wait_done(0, 100, "clr");
        chk("clr_latency", 32'(a_done_cyc - a_cmd_cyc), 32'd9);
        chk("clr_sck_falls", 32'(a_nfall - f0), 32'd1);
        chk("clr_sclr_low_falls", 32'(a_nclrf - c0), 32'd1);
        chk("clr_rck_falls", 32'(a_nrck - r0), 32'd1);
        chk("clr_chain_q", 32'(a_q[7:0]), 32'h00);
        chk("clr_no_data_accept", 32'(a_nacc - n0), 32'd0);
        chk("clr_ready_after", 32'(bus_a.IN_READY), 32'd1);
        @(negedge clk);
        bus_a.IN_VALID = 1'b0;
        chk("clr_next_accept", 32'(a_nacc - n0), 32'd1);
        chk("clr_next_accept_cyc", 32'(a_acc_cyc - a_done_cyc), 32'd1);
        wait_done(0, 100, "after_clr");
        chk("after_clr_q", 32'(a_q[7:0]), 32'h3C);

        // Back-to-back with IN_VALID held high
        @(negedge clk);
        n0 = a_nacc; d0 = a_ndone;
        bus_a.IN_DATA = 8'hFF;
        bus_a.IN_VALID = 1'b1;
        wait_acc(0, n0 + 1, 20, "b2b_first");
        bus_a.IN_DATA = 8'h01;
        wait_acc(0, n0 + 2, 100, "b2b_second");
        bus_a.IN_VALID = 1'b0;
        wait_done(0, 100, "b2b");
        chk("b2b_done_count", 32'(a_ndone - d0), 32'd2);
        chk("b2b_done_spacing", 32'(a_done_cyc - a_prev_done), 32'd38);
        chk("b2b_chain_q", 32'(a_q[7:0]), 32'h01);
        repeat (5) @(negedge clk);
        chk("b2b_accept_count", 32'(a_nacc - n0), 32'd2);

        // Reset in the middle of a transfer
        @(negedge clk);
        n0 = a_nacc; f0 = a_nfall;
        bus_a.IN_DATA = 8'hC3;
        bus_a.IN_VALID = 1'b1;
        wait_acc(0, n0 + 1, 20, "rmid");
        bus_a.IN_VALID = 1'b0;
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk);
                got = ((a_nfall - f0) >= 3);
            end
            chk("rmid_bit3_reached", 32'(got), 32'd1);
        end
        r0 = a_nrck; d0 = a_ndone;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rmid_sck",  32'(a_sck),  32'd1);
        chk("rmid_rck",  32'(a_rck),  32'd1);
        chk("rmid_sclr", 32'(a_sclr), 32'd1);
        chk("rmid_si",   32'(a_si),   32'd0);
        chk("rmid_done", 32'(bus_a.DONE), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rmid_ready", 32'(bus_a.IN_READY), 32'd1);
        repeat (60) @(negedge clk);
        chk("rmid_no_rck", 32'(a_nrck - r0), 32'd0);
        chk("rmid_no_done", 32'(a_ndone - d0), 32'd0);

        // OUT_EN raised mid-transfer
        @(negedge clk);
        chk("oe_low_before", 32'(a_oe), 32'd0);
        n0 = a_nacc; f0 = a_nfall;
        bus_a.IN_DATA = 8'h5A;
        bus_a.IN_VALID = 1'b1;
        wait_acc(0, n0 + 1, 20, "oe");
        bus_a.IN_VALID = 1'b0;
        repeat (10) @(negedge clk);
        chk("oe_still_low", 32'(a_oe), 32'd0);
        bus_a.OUT_EN = 1'b1;
        @(negedge clk);
`ifdef HC595_BLANK_EN
        chk("oe_blanked_busy", 32'(a_oe), 32'd0);
`else
        chk("oe_follows", 32'(a_oe), 32'd1);
`endif
        wait_done(0, 100, "oe");
        chk("oe_idle_high", 32'(a_oe), 32'd1);
        chk("oe_chain_q", 32'(a_q[7:0]), 32'h5A);

        // Randomized transfers on the 8-bit instance
        for (int k = 0; k < 6; k++) begin
            rd = 16'($urandom_range(0, 255));
            oe_req = 1'($urandom_range(0, 1));
            bus_a.OUT_EN = oe_req;
            run_xfer(0, rd, "rand_a");
            chk("rand_a_oe", 32'(a_oe), 32'(oe_req));
        end

        // Two-device chain
        run_xfer(1, 16'h12F0, "chain");
        chk("chain_near", 32'(b_q[7:0]), 32'hF0);
        chk("chain_far",  32'(b_q[15:8]), 32'h12);
        for (int k = 0; k < 4; k++) begin
            rd = 16'($urandom_range(0, 65535));
            run_xfer(1, rd, "rand_b");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
